// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Latency: accept at N, ALU evaluated in N+1, response held from N+2 (3-cycle best-case throughput).
// Backpressure: req_ready only in IDLE; response held until the owner's rsp_ready, non-owner ready ignored.
module alu_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [3:0]       req_sel_0,
    input  logic [3:0]       req_sel_1,
    input  logic [WIDTH-1:0] req_a_0,
    input  logic [WIDTH-1:0] req_a_1,
    input  logic [WIDTH-1:0] req_b_0,
    input  logic [WIDTH-1:0] req_b_1,
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic             busy,
    output logic [3:0]       alu_sel,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero
);

    // Selection code that makes the shared ALU forward operand a.
    localparam logic [3:0] ALU_PASS = 4'hF;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]       state_q, state_d;
    logic             last_q, last_d;
    logic             owner_q, owner_d;
    logic             busy_q, busy_d;
    logic [3:0]       sel_q, sel_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             zero_q, zero_d;

    logic             grant_idx;
    logic             accept;

    // On a tie the requester that did not win last time is served.
    always_comb begin
        grant_idx = (req_valid == 2'b11) ? ~last_q : req_valid[1];
        req_ready = 2'b00;
        if (rst && (state_q == S_IDLE) && (req_valid != 2'b00)) begin
            req_ready = grant_idx ? 2'b10 : 2'b01;
        end
        accept = |(req_valid & req_ready);
    end

    always_comb begin
        rsp_valid = 2'b00;
        if (rst && (state_q == S_RESP)) begin
            rsp_valid = owner_q ? 2'b10 : 2'b01;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        owner_d = owner_q;
        sel_d   = sel_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        zero_d  = zero_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_EXEC;
                    owner_d = grant_idx;
                    last_d  = grant_idx;
                    sel_d   = grant_idx ? req_sel_1 : req_sel_0;
                    a_d     = grant_idx ? req_a_1   : req_a_0;
                    b_d     = grant_idx ? req_b_1   : req_b_0;
                end
            end
            S_EXEC: begin
                state_d = S_RESP;
                res_d   = alu_result;
                zero_d  = alu_zero;
                sel_d   = ALU_PASS;
            end
            S_RESP: begin
                if (rsp_ready[owner_q]) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                sel_d   = ALU_PASS;
            end
        endcase
        busy_d = (state_d == S_EXEC) || (state_d == S_RESP);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            last_q  <= 1'b1;
            owner_q <= 1'b0;
            busy_q  <= 1'b0;
            sel_q   <= ALU_PASS;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            busy_q  <= busy_d;
            sel_q   <= sel_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
        end
    end

    assign busy       = busy_q;
    assign alu_sel    = sel_q;
    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign rsp_result = res_q;
    assign rsp_zero   = zero_q;

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (rst) begin
            assert ($onehot0(req_ready));
            assert ($onehot0(rsp_valid));
        end
    end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: transaction-level reference model checked every cycle plus directed literal checks.
module tb_alu_arbiter;
    localparam int W = 32;
    localparam logic [3:0] ALU_ADD  = 4'h0;
    localparam logic [3:0] ALU_SUB  = 4'h1;
    localparam logic [3:0] ALU_AND  = 4'h2;
    localparam logic [3:0] ALU_OR   = 4'h3;
    localparam logic [3:0] ALU_XOR  = 4'h4;
    localparam logic [3:0] ALU_PASS = 4'hF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic [1:0]   req_valid, req_ready;
    logic [3:0]   req_sel_0, req_sel_1;
    logic [W-1:0] req_a_0, req_a_1, req_b_0, req_b_1;
    logic [1:0]   rsp_valid, rsp_ready;
    logic [W-1:0] rsp_result;
    logic         rsp_zero, busy;
    logic [3:0]   alu_sel;
    logic [W-1:0] alu_a, alu_b, alu_result;
    logic         alu_zero;

    alu_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_sel_0(req_sel_0), .req_sel_1(req_sel_1),
        .req_a_0(req_a_0), .req_a_1(req_a_1),
        .req_b_0(req_b_0), .req_b_1(req_b_1),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero), .busy(busy),
        .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .alu_zero(alu_zero)
    );

    function automatic logic [W-1:0] alu_fn(input logic [3:0] s, input logic [W-1:0] a, input logic [W-1:0] b);
        case (s)
            ALU_ADD:  return a + b;
            ALU_SUB:  return a - b;
            ALU_AND:  return a & b;
            ALU_OR:   return a | b;
            ALU_XOR:  return a ^ b;
            ALU_PASS: return a;
            default:  return b;
        endcase
    endfunction

    always_comb begin
        alu_result = alu_fn(alu_sel, alu_a, alu_b);
        alu_zero   = (alu_result == '0);
    end

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: m_age = cycles since accept (-1 when no op in flight).
    int           m_age   = -1;
    bit           m_last  = 1'b1;
    bit           m_owner = 1'b0;
    logic [3:0]   m_sel   = ALU_PASS;
    logic [W-1:0] m_a     = '0;
    logic [W-1:0] m_b     = '0;
    logic [W-1:0] m_res   = '0;
    bit           m_zero  = 1'b0;
    int           g_idx[$];
    int           g_cyc[$];
    logic [W-1:0] r_q[$];

    initial begin : compare
        bit         pick;
        logic [1:0] e_rdy, e_rv;
        @(posedge clk);
        forever begin
            @(negedge clk);
            pick  = (req_valid == 2'b11) ? !m_last : req_valid[1];
            e_rdy = (rst && m_age < 0 && req_valid != 2'b00) ? (pick ? 2'b10 : 2'b01) : 2'b00;
            e_rv  = (rst && m_age >= 2) ? (m_owner ? 2'b10 : 2'b01) : 2'b00;
            chk("req_ready", W'(req_ready), W'(e_rdy));
            chk("rsp_valid", W'(rsp_valid), W'(e_rv));
            chk("busy", W'(busy), W'(m_age >= 1));
            chk("alu_sel", W'(alu_sel), W'((m_age == 1) ? m_sel : ALU_PASS));
            chk("alu_a", alu_a, m_a);
            chk("alu_b", alu_b, m_b);
            chk("rsp_result", rsp_result, m_res);
            chk("rsp_zero", W'(rsp_zero), W'(m_zero));
            if (!rst) begin
                m_age = -1; m_last = 1'b1; m_owner = 1'b0; m_sel = ALU_PASS;
                m_a = '0; m_b = '0; m_res = '0; m_zero = 1'b0;
            end else if (m_age < 0) begin
                if ((e_rdy & req_valid) != 2'b00) begin
                    m_age = 1; m_owner = pick; m_last = pick;
                    m_sel = pick ? req_sel_1 : req_sel_0;
                    m_a   = pick ? req_a_1 : req_a_0;
                    m_b   = pick ? req_b_1 : req_b_0;
                    g_idx.push_back(int'(pick));
                    g_cyc.push_back(cyc);
                end
            end else if (m_age == 1) begin
                m_age = 2;
                m_res = alu_fn(m_sel, m_a, m_b);
                m_zero = (m_res == '0);
            end else if (rsp_ready[m_owner]) begin
                r_q.push_back(m_res);
                m_age = -1;
            end else begin
                m_age++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; req_valid = 2'b11; rsp_ready = 2'b00;
        req_sel_0 = ALU_ADD; req_sel_1 = ALU_SUB;
        req_a_0 = 32'd1; req_b_0 = 32'd2; req_a_1 = 32'd3; req_b_1 = 32'd4;

        // Reset defaults with both requesters valid
        repeat (3) begin
            tick();
            chk("rst_req_ready", W'(req_ready), '0);
            chk("rst_rsp_valid", W'(rsp_valid), '0);
            chk("rst_alu_sel", W'(alu_sel), W'(ALU_PASS));
            chk("rst_busy", W'(busy), '0);
        end
        rst = 1'b1; req_valid = 2'b00;
        tick();

        // Single op: port 0 ADD 5+7
        req_valid = 2'b01; req_sel_0 = ALU_ADD; req_a_0 = 32'd5; req_b_0 = 32'd7;
        #1 chk("single_ready", W'(req_ready), W'(2'b01));
        tick();
        req_valid = 2'b00;
        chk("single_alu_a", alu_a, 32'd5);
        chk("single_alu_b", alu_b, 32'd7);
        chk("single_alu_sel", W'(alu_sel), W'(ALU_ADD));
        tick();
        chk("single_rsp_valid", W'(rsp_valid), W'(2'b01));
        chk("single_result", rsp_result, 32'd12);
        chk("single_zero", W'(rsp_zero), '0);
        rsp_ready = 2'b01;
        tick();
        chk("single_rsp_clr", W'(rsp_valid), '0);
        rsp_ready = 2'b00;

        // Zero flag and backpressure: port 1 SUB 9-9, port 0 waiting
        req_valid = 2'b10; req_sel_1 = ALU_SUB; req_a_1 = 32'd9; req_b_1 = 32'd9;
        tick();
        req_valid = 2'b11; req_sel_0 = ALU_ADD; req_a_0 = 32'd3; req_b_0 = 32'd4;
        #1 chk("bp_exec_ready", W'(req_ready), '0);
        tick();
        repeat (4) begin
            chk("bp_rsp_valid", W'(rsp_valid), W'(2'b10));
            chk("bp_result", rsp_result, 32'd0);
            chk("bp_zero", W'(rsp_zero), W'(1'b1));
            chk("bp_ready_blocked", W'(req_ready), '0);
            tick();
        end
        rsp_ready = 2'b10;
        #1 chk("bp_consume_ready", W'(req_ready), '0);
        tick();
        chk("bp_waiter_granted", W'(req_ready), W'(2'b01));
        rsp_ready = 2'b00;
        tick();
        req_valid = 2'b00;
        tick();
        chk("bp_waiter_result", rsp_result, 32'd7);
        rsp_ready = 2'b01;
        tick();
        rsp_ready = 2'b00;

        // Wrong-port ready in RESP for owner 0
        req_valid = 2'b01; req_sel_0 = ALU_AND; req_a_0 = 32'hC; req_b_0 = 32'hA;
        tick();
        req_valid = 2'b00;
        tick();
        rsp_ready = 2'b10;
        repeat (3) begin
            #1;
            chk("wp_rsp_valid", W'(rsp_valid), W'(2'b01));
            chk("wp_busy", W'(busy), W'(1'b1));
            chk("wp_result", rsp_result, 32'h8);
            tick();
        end
        rsp_ready = 2'b01;
        tick();
        chk("wp_done", W'(rsp_valid), '0);
        rsp_ready = 2'b00;

        // Mid-operation reset during EXEC
        req_valid = 2'b10; req_sel_1 = ALU_SUB; req_a_1 = 32'd10; req_b_1 = 32'd3;
        tick();
        rst = 1'b0; req_valid = 2'b00;
        tick();
        chk("mr_busy", W'(busy), '0);
        chk("mr_rsp_valid", W'(rsp_valid), '0);
        chk("mr_result", rsp_result, '0);
        chk("mr_alu_a", alu_a, '0);
        rst = 1'b1;
        repeat (4) begin
            tick();
            chk("mr_no_rsp", W'(rsp_valid), '0);
        end

        // Round-robin with both continuously valid, first tie after reset
        g_idx.delete(); g_cyc.delete(); r_q.delete();
        req_valid = 2'b11; rsp_ready = 2'b11;
        req_sel_0 = ALU_ADD; req_a_0 = 32'd1;    req_b_0 = 32'd1;
        req_sel_1 = ALU_XOR; req_a_1 = 32'hF0;   req_b_1 = 32'hFF;
        repeat (13) tick();
        req_valid = 2'b00;
        repeat (4) tick();
        chk("rr_grant_count", W'(g_idx.size() >= 4), W'(1'b1));
        chk("rr_result_count", W'(r_q.size() >= 4), W'(1'b1));
        if (g_idx.size() >= 4) begin
            for (int i = 0; i < 4; i++) chk("rr_grant", W'(g_idx[i]), W'(i % 2));
            for (int i = 1; i < 4; i++) chk("rr_spacing", W'(g_cyc[i] - g_cyc[i-1]), 32'd3);
        end
        if (r_q.size() >= 4) begin
            for (int i = 0; i < 4; i++) chk("rr_result", r_q[i], (i % 2 == 1) ? 32'h0F : 32'd2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
